// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensor levels and enable in, clean coin pulses and status out.
// The slave modport is the acceptor's view; the master modport is the driver's view.
interface coin_acceptor_if;
    logic       five_raw;
    logic       ten_raw;
    logic       enable;
    logic       five_in;
    logic       ten_in;
    logic       busy;
    logic       jam;
    logic [7:0] coin_count;

    modport master (
        output five_raw, ten_raw, enable,
        input  five_in, ten_in, busy, jam, coin_count
    );

    modport slave (
        input  five_raw, ten_raw, enable,
        output five_in, ten_in, busy, jam, coin_count
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises/debounces coin sensors, emits one clean pulse per coin.
// Optional jam detection is compiled in when COIN_JAM_DETECT_EN is defined.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 2,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input logic           clk,
    input logic           rst,
    coin_acceptor_if.slave bus
);

    localparam logic [7:0] DebLast  = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] LockLast = 8'(LOCKOUT_CYCLES);

`ifdef COIN_JAM_DETECT_EN
    typedef enum logic [2:0] {StIdle, StQual, StWaitRel, StLockout, StJam} state_e;
    localparam int unsigned     JamW    = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;
    localparam logic [JamW-1:0] JamLast = JamW'(JAM_CYCLES - 1);
    logic [JamW-1:0] jam_cnt_q;
    logic            jam_q;
`else
    typedef enum logic [2:0] {StIdle, StQual, StWaitRel, StLockout} state_e;
    logic [31:0] unused_jam_cycles;
    assign unused_jam_cycles = JAM_CYCLES;
`endif

    state_e     state_q;
    logic [1:0] sync5_q, sync10_q;
    logic [7:0] cnt_q;
    logic [7:0] coin_count_q;
    logic       is_ten_q;
    logic       five_in_q, ten_in_q;

    logic s5, s10, qual_ok, released;
    assign s5       = sync5_q[1];
    assign s10      = sync10_q[1];
    assign released = !s5 && !s10;
    // The latched sensor must stay the only one high for the whole qualification window.
    assign qual_ok  = bus.enable && (is_ten_q ? (s10 && !s5) : (s5 && !s10));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync5_q      <= '0;
            sync10_q     <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            coin_count_q <= '0;
            is_ten_q     <= 1'b0;
            five_in_q    <= 1'b0;
            ten_in_q     <= 1'b0;
`ifdef COIN_JAM_DETECT_EN
            jam_cnt_q    <= '0;
            jam_q        <= 1'b0;
`endif
        end else begin
            sync5_q   <= {sync5_q[0], bus.five_raw};
            sync10_q  <= {sync10_q[0], bus.ten_raw};
            five_in_q <= 1'b0;
            ten_in_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        if (s5 && s10) begin
                            state_q <= StWaitRel;
`ifdef COIN_JAM_DETECT_EN
                            jam_cnt_q <= '0;
`endif
                        end else if (s5 ^ s10) begin
                            state_q  <= StQual;
                            is_ten_q <= s10;
                            cnt_q    <= 8'd1;
                        end
                    end
                end
                StQual: begin
                    if (!qual_ok) begin
                        state_q <= StIdle;
                    end else if (cnt_q == DebLast) begin
                        five_in_q    <= !is_ten_q;
                        ten_in_q     <= is_ten_q;
                        coin_count_q <= coin_count_q + 8'd1;
                        state_q      <= StWaitRel;
`ifdef COIN_JAM_DETECT_EN
                        jam_cnt_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWaitRel: begin
                    if (released) begin
                        state_q <= StLockout;
                        cnt_q   <= 8'd1;
`ifdef COIN_JAM_DETECT_EN
                    end else if (jam_cnt_q == JamLast) begin
                        state_q <= StJam;
                        jam_q   <= 1'b1;
                    end else begin
                        jam_cnt_q <= jam_cnt_q + 1'b1;
`endif
                    end
                end
                StLockout: begin
                    if (cnt_q == LockLast) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`ifdef COIN_JAM_DETECT_EN
                StJam: begin
                    if (released) begin
                        state_q <= StLockout;
                        cnt_q   <= 8'd1;
                        jam_q   <= 1'b0;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.five_in    = five_in_q;
    assign bus.ten_in     = ten_in_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.coin_count = coin_count_q;
`ifdef COIN_JAM_DETECT_EN
    assign bus.jam        = jam_q;
`else
    assign bus.jam        = 1'b0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: coin episodes are generated at random, expected pulses
// (type, cycle, count) are queued from the acceptance rules, and a monitor checks the DUT output.
module tb_coin_acceptor;

    localparam int unsigned D = 4;
    localparam int unsigned L = 2;
    localparam int unsigned J = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coin_acceptor_if bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .LOCKOUT_CYCLES  (L),
        .JAM_CYCLES      (J)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        ten;
        logic [31:0] at;
        logic [7:0]  count;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic [7:0]  model_count = 8'd0;
    bit          jam_window  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 five, 1 ten, 2 both at once. mode: 0 enabled, 1 disabled, 2 enable dropped mid-QUAL.
    task automatic episode(input int kind, input int w, input int mode);
        int unsigned c;
        bit          acc;
        int          drop;
        exp_t        e;
        c    = cyc;
        acc  = (kind != 2) && (mode == 0) && (w >= int'(D) + 1);
        drop = (mode == 2) ? int'($urandom_range(3, D + 1)) : -1;
        if (acc) begin
            model_count = model_count + 8'd1;
            e.ten   = (kind == 1);
            e.at    = c + D + 3;
            e.count = model_count;
            sb.push_back(e);
        end
        bus.five_raw = (kind != 1);
        bus.ten_raw  = (kind != 0);
        bus.enable   = (mode != 1);
        for (int i = 0; i < w; i++) begin
            if (i == drop) bus.enable = 1'b0;
            tick(1);
        end
        bus.five_raw = 1'b0;
        bus.ten_raw  = 1'b0;
        // Release reaches the FSM 3 edges later, then LOCKOUT holds busy for L cycles.
        tick(2 + L);
        check("busy_in_lockout", bus.busy, 32'(acc || (kind == 2 && mode != 1)));
        tick(1);
        check("busy_back_idle", bus.busy, 0);
        bus.enable = 1'b1;
        tick(int'($urandom_range(0, 3)));
    endtask

    // Monitor: pops expectations whenever a pulse appears, flags late or extra pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.five_in && bus.ten_in) begin
                    total++;
                    bad++;
                    $display("FAIL both_pulses: got five=1 ten=1 expected at most one (cycle %0d)",
                             cyc);
                end
                if (bus.five_in || bus.ten_in) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got five=%0d ten=%0d expected none (cycle %0d)",
                                 bus.five_in, bus.ten_in, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_is_ten", bus.ten_in, e.ten);
                        check("pulse_cycle", cyc, e.at);
                        check("coin_count", bus.coin_count, e.count);
                    end
                end else if (sb.size() > 0 && sb[0].at < cyc) begin
                    e = sb.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_pulse: got none expected pulse at cycle %0d (cycle %0d)",
                             e.at, cyc);
                end
                if (!jam_window) check("jam_idle", bus.jam, 0);
            end
        end
    end

    initial begin
        int unsigned c;
        logic [7:0]  cnt0;
        bus.five_raw = 1'b0;
        bus.ten_raw  = 1'b0;
        bus.enable   = 1'b1;
        rst          = 1'b1;
        tick(3);
        check("rst_five_in", bus.five_in, 0);
        check("rst_ten_in", bus.ten_in, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_jam", bus.jam, 0);
        check("rst_coin_count", bus.coin_count, 0);
        rst = 1'b0;
        tick(2);

        episode(0, 20, 0);
        episode(1, 3, 0);
        episode(2, 10, 0);
        episode(1, 10, 0);
        episode(0, 10, 1);
        episode(0, 10, 2);
        episode(0, 5, 0);
        episode(1, 4, 0);

        // Reset in the middle of qualification: coin aborted, everything cleared.
        c = cyc;
        bus.five_raw = 1'b1;
        tick(4);
        rst          = 1'b1;
        bus.five_raw = 1'b0;
        tick(1);
        check("midqual_rst_five_in", bus.five_in, 0);
        check("midqual_rst_ten_in", bus.ten_in, 0);
        check("midqual_rst_busy", bus.busy, 0);
        check("midqual_rst_count", bus.coin_count, 0);
        model_count = 8'd0;
        rst = 1'b0;
        tick(3);
        episode(0, 8, 0);

`ifdef COIN_JAM_DETECT_EN
        jam_window = 1'b1;
        c = cyc;
        fork
            episode(0, 100, 0);
            begin
                tick(int'(D + J) + 2);
                check("jam_before_limit", bus.jam, 0);
                tick(1);
                check("jam_at_limit", bus.jam, 1);
                tick(100 + 2 - int'(D + J) - 3);
                check("jam_until_release", bus.jam, 1);
                tick(1);
                check("jam_cleared", bus.jam, 0);
            end
        join
        jam_window = 1'b0;
`else
        episode(0, 100, 0);
`endif

        for (int n = 0; n < 120; n++) begin
            int k, m, w;
            k = int'($urandom_range(0, 2));
            m = int'($urandom_range(0, 3));
            m = (m < 2) ? 0 : m - 1;
            w = (m == 2) ? int'(D) + 2 + int'($urandom_range(0, 3))
                         : int'($urandom_range(1, 2 * D + 4));
            episode(k, w, m);
        end

        cnt0 = model_count;
        for (int n = 0; n < 256; n++) begin
            episode(int'($urandom_range(0, 1)), int'(D) + 1 + int'($urandom_range(0, 2)), 0);
        end
        check("count_wrapped", bus.coin_count, cnt0);

        for (int n = 0; n < 20 && sb.size() > 0; n++) tick(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
